amp_result_collector: RTL and testbench
=======================================

AMP_RESULT_COLLECTOR -- requirements
Module: amp_result_collector

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entry count (power of two, 2..64).
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of the statistics counters.
REQ-003 SHALL have port clk_i, input, 1, sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, reset: asynchronous and active-high.
REQ-005 SHALL have port in_val_i, input, 1, amplifier result valid (one-cycle pulse per result).
REQ-006 SHALL have port in_data_i, input, 32, amplifier result: [31:24] sequence number, [23:0] amplified value (unsigned).
REQ-007 SHALL have port clr_stat_i, input, 1, clears the counters and the sequence tracker.
REQ-008 SHALL have port out_rdy_i, input, 1, consumer ready.
REQ-009 SHALL have port out_val_o, output, 1, head entry valid.
REQ-010 SHALL have port out_data_o, output, 25, head entry: [24] overflow flag, [23:16] sequence number, [15:0] saturated value.
REQ-011 SHALL have port level_o, output, log2(DEPTH)+1, current occupancy.
REQ-012 SHALL have ports full_o and empty_o, output, 1 each, occupancy flags.
REQ-013 SHALL have port drop_cnt_o, output, CNT_WIDTH, count of results lost while the FIFO was full.
REQ-014 SHALL have port seq_err_cnt_o, output, CNT_WIDTH, count of sequence discontinuities.

Function
REQ-015 SHALL on in_val_i=1 form the entry {ovf, no, sat}: ovf=1 and sat=16'hFFFF if in_data_i[23:16]!=0, else ovf=0 and sat=in_data_i[15:0].
REQ-016 SHALL write the entry at the clock edge where in_val_i=1 and (not full, or full with a pop in the same cycle).
REQ-017 SHALL treat in_val_i=1 while full with no pop as a drop: no write; drop_cnt_o increments, saturating at all-ones.
REQ-018 SHALL be first-word-fall-through: out_val_o = !empty_o; out_data_o shows the head entry, from registered storage.
REQ-019 SHALL pop at the edge where out_val_o=1 and out_rdy_i=1; out_data_o SHALL hold stable while out_val_o=1 and out_rdy_i=0.
REQ-020 SHALL make a written entry visible on out_val_o/out_data_o in the cycle after the write edge (latency 1 when empty).
REQ-021 SHALL on a simultaneous push and pop leave level_o unchanged; when empty, a same-cycle push SHALL NOT be popped.
REQ-022 SHALL wrap read and write pointers modulo DEPTH; full_o = (level_o==DEPTH), empty_o = (level_o==0).
REQ-023 SHALL implement a sequence tracker FSM with states IDLE (no expectation) and TRACK (expect = last no + 1 mod 256).
REQ-024 SHALL in IDLE, on in_val_i, store the number and go to TRACK; no error is counted.
REQ-025 SHALL in TRACK, on in_val_i with no != expect, increment seq_err_cnt_o (saturating); on every in_val_i, update expect to no+1 (255 wraps to 0).
REQ-026 SHALL run the tracker on all in_val_i pulses, including dropped ones.
REQ-027 SHALL on clr_stat_i=1 zero both counters and force IDLE at the next edge; clear SHALL win over a same-cycle increment; FIFO contents SHALL be unaffected.

Reset
REQ-028 SHALL while rst_i=1 asynchronously force: pointers and level to 0, out_val_o=0, empty_o=1, full_o=0, out_data_o=0, both counters 0, FSM=IDLE.
REQ-029 SHALL discard all entries on reset mid-operation; out_val_o SHALL drop in the same cycle rst_i asserts.

Structure
REQ-030 SHALL take the widths (32-bit input, 8-bit sequence number, 16-bit saturated value, 25-bit entry) from the shared amplifier parameter package, amp_pkg.
REQ-031 SHALL instantiate one sub-module, amp_sync_fifo (parameterised width/depth, FWFT); saturation, the tracker and the counters stay in the top level.

Verification
REQ-032 SHALL cover this case: reset, then push no=0x01 value=0x000100 with out_rdy_i=1 -> next cycle out_val_o=1, out_data_o=0x0010100, then empty.
REQ-033 SHALL cover this case: push value=0x012345 -> out_data_o[24]=1, [15:0]=0xFFFF.
REQ-034 SHALL cover this case: out_rdy_i=0, 10 pushes at DEPTH=8 -> full_o=1, level_o=8, drop_cnt_o=2; draining then returns the first 8 in order.
REQ-035 SHALL cover this case: sequence 0xFE,0xFF,0x00,0x02 -> seq_err_cnt_o=1 (wrap 0xFF->0x00 accepted).
REQ-036 SHALL cover this case: full FIFO with out_rdy_i=1 and in_val_i=1 in the same cycle -> no drop, level_o stays 8.
REQ-037 SHALL cover this case: clr_stat_i pulse coincident with a drop -> drop_cnt_o=0, next number accepted without error, FIFO level unchanged.

Source files
------------

// File: rtl/amp_pkg.sv
// Shared amplifier widths, FIFO entry layout and sequence-tracker states.
// The entry former lives here so every consumer of amplifier results saturates identically.
package amp_pkg;

  localparam int IN_W    = 32;
  localparam int SEQ_W   = 8;
  localparam int VAL_W   = 24;
  localparam int SAT_W   = 16;
  localparam int ENTRY_W = 25;

  typedef struct packed {
    logic             ovf;
    logic [SEQ_W-1:0] no;
    logic [SAT_W-1:0] sat;
  } entry_t;

  typedef enum logic {
    IDLE,
    TRACK
  } trk_state_t;

  // Any set bit above the 16-bit range means the value cannot be represented.
  function automatic entry_t make_entry(input logic [IN_W-1:0] data);
    entry_t e;
    e.no  = data[IN_W-1 -: SEQ_W];
    e.ovf = |data[VAL_W-1:SAT_W];
    e.sat = e.ovf ? {SAT_W{1'b1}} : data[SAT_W-1:0];
    return e;
  endfunction

endpackage

// File: rtl/amp_sync_fifo.sv
// Generic first-word-fall-through synchronous FIFO; the head is read straight
// from the storage array, so data holds while the consumer stalls.
module amp_sync_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     rdy_i,
  output logic                     val_o,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;
  logic             do_push;

  assign empty_o = (level_o == '0);
  assign full_o  = (level_o == LVL_W'(DEPTH));
  assign val_o   = !empty_o;

  // A push while full is legal only when the head leaves at the same edge,
  // because the write lands exactly on the slot being vacated.
  assign do_pop  = val_o && rdy_i;
  assign do_push = push_i && (!full_o || do_pop);

  // Masking with empty keeps the output at zero during and after reset.
  assign data_o  = empty_o ? '0 : mem[rd_ptr];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_o <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level_o <= level_o + LVL_W'(1);
        2'b01:   level_o <= level_o - LVL_W'(1);
        default: level_o <= level_o;
      endcase
    end
  end

  // NOTE: storage has no reset; stale contents are unreachable once the
  // pointers and level are cleared, and leaving it out keeps it RAM-mappable.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_data_i;
  end

endmodule

// File: rtl/amp_result_collector.sv
// Collects amplifier results: saturates them into FIFO entries, counts drops
// while full and tracks sequence-number continuity.
module amp_result_collector
  import amp_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_val_i,
  input  logic [IN_W-1:0]        in_data_i,
  input  logic                   clr_stat_i,
  input  logic                   out_rdy_i,
  output logic                   out_val_o,
  output logic [ENTRY_W-1:0]     out_data_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [CNT_WIDTH-1:0]   drop_cnt_o,
  output logic [CNT_WIDTH-1:0]   seq_err_cnt_o
);

  entry_t           entry;
  logic             drop;
  logic             seq_err;
  trk_state_t       state_q;
  trk_state_t       state_d;
  logic [SEQ_W-1:0] expect_q;

  assign entry = make_entry(in_data_i);
  assign drop  = in_val_i && full_o && !(out_val_o && out_rdy_i);

  amp_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (in_val_i),
    .push_data_i (entry),
    .rdy_i       (out_rdy_i),
    .val_o       (out_val_o),
    .data_o      (out_data_o),
    .level_o     (level_o),
    .full_o      (full_o),
    .empty_o     (empty_o)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    seq_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (!clr_stat_i && in_val_i) state_d = TRACK;
      end
      TRACK: begin
        if (clr_stat_i) begin
          state_d = IDLE;
        end else if (in_val_i && entry.no != expect_q) begin
          seq_err = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The expectation follows every pulse, including dropped ones; 8-bit wrap is free.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      expect_q <= '0;
    end else if (in_val_i && !clr_stat_i) begin
      expect_q <= entry.no + SEQ_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      drop_cnt_o    <= '0;
      seq_err_cnt_o <= '0;
    end else if (clr_stat_i) begin
      drop_cnt_o    <= '0;
      seq_err_cnt_o <= '0;
    end else begin
      if (drop && drop_cnt_o != '1)       drop_cnt_o    <= drop_cnt_o + CNT_WIDTH'(1);
      if (seq_err && seq_err_cnt_o != '1) seq_err_cnt_o <= seq_err_cnt_o + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_amp_result_collector.sv
// Directed and randomized checks of amp_result_collector against a queue-based
// model of the FIFO, counters and sequence rule.
module tb_amp_result_collector;

  localparam int DEPTH     = 8;
  localparam int CNT_WIDTH = 16;
  localparam int CNT_MAX   = (1 << CNT_WIDTH) - 1;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   in_val;
  logic [31:0]            in_data;
  logic                   clr_stat;
  logic                   out_rdy;
  logic                   out_val;
  logic [24:0]            out_data;
  logic [$clog2(DEPTH):0] level;
  logic                   full;
  logic                   empty;
  logic [CNT_WIDTH-1:0]   drop_cnt;
  logic [CNT_WIDTH-1:0]   seq_err_cnt;

  amp_result_collector #(
    .DEPTH     (DEPTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .in_val_i      (in_val),
    .in_data_i     (in_data),
    .clr_stat_i    (clr_stat),
    .out_rdy_i     (out_rdy),
    .out_val_o     (out_val),
    .out_data_o    (out_data),
    .level_o       (level),
    .full_o        (full),
    .empty_o       (empty),
    .drop_cnt_o    (drop_cnt),
    .seq_err_cnt_o (seq_err_cnt)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [24:0] q[$];
  int          m_drops;
  int          m_errs;
  bit          m_have_last;
  int          m_last_no;
  int          seq;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Saturation rule stated on the 24-bit magnitude rather than on bit fields.
  function automatic logic [24:0] model_entry(input logic [31:0] d);
    int value;
    int no;
    value = int'(d[23:0]);
    no    = int'(d[31:24]);
    if (value > 65535) return {1'b1, 8'(no), 16'hFFFF};
    return {1'b0, 8'(no), 16'(value)};
  endfunction

  task automatic model_clear_all();
    q.delete();
    m_drops     = 0;
    m_errs      = 0;
    m_have_last = 0;
    m_last_no   = 0;
  endtask

  task automatic model_step(input logic v, input logic [31:0] d, input logic c, input logic r);
    bit pop;
    bit was_full;
    int no;
    pop      = (q.size() > 0) && r;
    was_full = (q.size() == DEPTH);
    if (v) begin
      no = int'(d[31:24]);
      if (m_have_last && no != (m_last_no + 1) % 256 && m_errs < CNT_MAX) m_errs++;
      if (was_full && !pop && m_drops < CNT_MAX) m_drops++;
      m_have_last = 1;
      m_last_no   = no;
    end
    if (c) begin
      m_drops     = 0;
      m_errs      = 0;
      m_have_last = 0;
    end
    if (pop) void'(q.pop_front());
    if (v && (!was_full || pop)) q.push_back(model_entry(d));
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".out_val"}, 32'(out_val), 32'(q.size() > 0));
    if (q.size() > 0) check({tag, ".out_data"}, 32'(out_data), 32'(q[0]));
    check({tag, ".level"}, 32'(level), 32'(q.size()));
    check({tag, ".full"}, 32'(full), 32'(q.size() == DEPTH));
    check({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
    check({tag, ".drop_cnt"}, 32'(drop_cnt), 32'(m_drops));
    check({tag, ".seq_err_cnt"}, 32'(seq_err_cnt), 32'(m_errs));
  endtask

  task automatic step(input string tag, input logic v, input logic [31:0] d,
                      input logic c, input logic r);
    @(negedge clk);
    in_val   = v;
    in_data  = d;
    clr_stat = c;
    out_rdy  = r;
    model_step(v, d, c, r);
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic push(input string tag, input int no, input int value, input logic r);
    step(tag, 1'b1, {8'(no), 24'(value)}, 1'b0, r);
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk);
    in_val   = 1'b0;
    in_data  = '0;
    clr_stat = 1'b0;
    out_rdy  = 1'b0;
    rst      = 1'b1;
    #1;
    model_clear_all();
    check_outputs(tag);
    check({tag, ".out_data_zero"}, 32'(out_data), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic        v;
    logic        c;
    logic        r;
    int          value;

    rst      = 1'b0;
    in_val   = 1'b0;
    in_data  = '0;
    clr_stat = 1'b0;
    out_rdy  = 1'b0;
    model_clear_all();

    apply_reset("reset");

    // First result appears one cycle after its write edge and is then consumed.
    push("first", 8'h01, 24'h000100, 1'b1);
    check("first.data_const", 32'(out_data), 32'h0010100);
    check("first.val_const", 32'(out_val), 32'h1);
    step("first_drain", 1'b0, '0, 1'b0, 1'b1);
    check("first.empty_const", 32'(empty), 32'h1);

    push("sat", 8'h02, 24'h012345, 1'b0);
    check("sat.ovf", 32'(out_data[24]), 32'h1);
    check("sat.value", 32'(out_data[15:0]), 32'hFFFF);
    step("sat_drain", 1'b0, '0, 1'b0, 1'b1);

    // Ten pushes into eight slots with the consumer stalled.
    seq = 3;
    for (int i = 0; i < 10; i++) begin
      push("fill", seq, 24'h000010 + i, 1'b0);
      seq = (seq + 1) % 256;
    end
    check("fill.full_const", 32'(full), 32'h1);
    check("fill.level_const", 32'(level), 32'd8);
    check("fill.drop_const", 32'(drop_cnt), 32'd2);
    for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, '0, 1'b0, 1'b1);

    // Full FIFO accepting a push because the head leaves at the same edge.
    for (int i = 0; i < DEPTH; i++) begin
      push("refill", seq, 24'h000400 + i, 1'b0);
      seq = (seq + 1) % 256;
    end
    push("push_pop_full", seq, 24'h00ABCD, 1'b1);
    seq = (seq + 1) % 256;
    check("push_pop_full.level_const", 32'(level), 32'd8);
    check("push_pop_full.drop_const", 32'(drop_cnt), 32'd2);

    // Clear coincident with a drop, then an arbitrary number is accepted cleanly.
    step("clr_drop", 1'b1, {8'(seq), 24'h000001}, 1'b1, 1'b0);
    check("clr_drop.drop_const", 32'(drop_cnt), 32'd0);
    check("clr_drop.level_const", 32'(level), 32'd8);
    push("after_clr", 8'h77, 24'h000002, 1'b1);
    check("after_clr.err_const", 32'(seq_err_cnt), 32'd0);
    check("after_clr.level_const", 32'(level), 32'd8);
    for (int i = 0; i < DEPTH; i++) step("drain2", 1'b0, '0, 1'b0, 1'b1);

    // Sequence wrap 0xFF->0x00 is continuous; 0x00->0x02 is one gap.
    step("clr_seq", 1'b0, '0, 1'b1, 1'b1);
    push("wrap_fe", 8'hFE, 24'h000005, 1'b1);
    push("wrap_ff", 8'hFF, 24'h000006, 1'b1);
    push("wrap_00", 8'h00, 24'h000007, 1'b1);
    push("wrap_02", 8'h02, 24'h000008, 1'b1);
    check("wrap.err_const", 32'(seq_err_cnt), 32'd1);
    step("wrap_drain", 1'b0, '0, 1'b0, 1'b1);

    // Reset in the middle of traffic discards everything immediately.
    for (int i = 0; i < 3; i++) push("pre_reset", 8'h10 + i, 24'h000020, 1'b0);
    push("pre_reset_gap", 8'h40, 24'h000020, 1'b0);
    apply_reset("mid_reset");

    seq = 0;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 2) != 0);
      c = ($urandom_range(0, 39) == 0);
      r = (i % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) seq = $urandom_range(0, 255);
      value = ($urandom_range(0, 3) == 0) ? int'($urandom & 32'h00FF_FFFF)
                                          : int'($urandom & 32'h0000_FFFF);
      step("random", v, {8'(seq), 24'(value)}, c, r);
      if (v) seq = (seq + 1) % 256;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
